// File: rtl/up_dn_cntr_param.sv
// Parametrised up/down counter with a [MIN_VAL, MAX_VAL] window, wrap or saturate, load and registered flags.
// Define UP_DN_CNTR_STEP_EN to add a `step` input that sets the count stride (default stride is 1).
module up_dn_cntr_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter bit          SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dnb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UP_DN_CNTR_STEP_EN
  input  logic [WIDTH-1:0] step,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LP_MIN_W = MIN_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LP_MAX_W = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH:0]   LP_MIN   = {1'b0, LP_MIN_W};
  localparam logic [WIDTH:0]   LP_MAX   = {1'b0, LP_MAX_W};
  localparam logic [WIDTH:0]   LP_ONE   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   LP_SPAN  = LP_MAX - LP_MIN + LP_ONE;

  logic [WIDTH-1:0] r_cnt;
  logic             r_at_max;
  logic             r_at_min;
  logic             r_wrap;

  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_cur;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dn_lim;
  logic [WIDTH-1:0] w_nxt;
  logic             w_nxt_wrap;

  function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] v);
    if ({1'b0, v} < LP_MIN) begin
      return LP_MIN_W;
    end else if ({1'b0, v} > LP_MAX) begin
      return LP_MAX_W;
    end else begin
      return v;
    end
  endfunction

  // Stride selection: a step wider than the window is trimmed to the window size.
  always_comb begin
`ifdef UP_DN_CNTR_STEP_EN
    if ({1'b0, step} > LP_SPAN) begin
      w_s = LP_SPAN;
    end else begin
      w_s = {1'b0, step};
    end
`else
    w_s = LP_ONE;
`endif
  end

  // Next-state selection in priority order load > count > hold; arithmetic is one bit wider than the count.
  always_comb begin
    w_cur      = {1'b0, r_cnt};
    w_sum      = w_cur + w_s;
    w_dn_lim   = LP_MIN + w_s;
    w_nxt      = r_cnt;
    w_nxt_wrap = 1'b0;
    if (load) begin
      w_nxt      = f_clamp(load_val);
      w_nxt_wrap = 1'b0;
    end else if (en) begin
      if (up_dnb) begin
        if (w_sum > LP_MAX) begin
          w_nxt_wrap = 1'b1;
          if (SAT_MODE) begin
            w_nxt = LP_MAX_W;
          end else begin
            w_nxt = WIDTH'(LP_MIN + (w_sum - LP_MAX - LP_ONE));
          end
        end else begin
          w_nxt = WIDTH'(w_sum);
        end
      end else begin
        // cnt - s < MIN rewritten as cnt < MIN + s to stay non-negative
        if (w_cur < w_dn_lim) begin
          w_nxt_wrap = 1'b1;
          if (SAT_MODE) begin
            w_nxt = LP_MIN_W;
          end else begin
            w_nxt = WIDTH'(LP_MAX - (w_dn_lim - w_cur - LP_ONE));
          end
        end else begin
          w_nxt = WIDTH'(w_cur - w_s);
        end
      end
    end else begin
      w_nxt      = r_cnt;
      w_nxt_wrap = 1'b0;
    end
  end

  // Count register and flags, all derived from the same next value so they update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt    <= LP_MIN_W;
      r_at_max <= 1'b0;
      r_at_min <= 1'b1;
      r_wrap   <= 1'b0;
    end else begin
      r_cnt    <= w_nxt;
      r_at_max <= (w_nxt == LP_MAX_W);
      r_at_min <= (w_nxt == LP_MIN_W);
      r_wrap   <= w_nxt_wrap;
    end
  end

  assign cnt    = r_cnt;
  assign at_max = r_at_max;
  assign at_min = r_at_min;
  assign wrap   = r_wrap;

endmodule

// File: doc/up_dn_cntr_param.md
# up_dn_cntr_param

Parametrised synchronous up/down counter. It generalises the fixed 4-bit up/down counter to:
- configurable width and count window [MIN_VAL, MAX_VAL];
- a choice of wrap or saturate at the window limits;
- count enable and parallel load;
- registered boundary/event flags.

It sits in the miscellaneous utility set as the common counter for timers, address generators and pattern sequencers.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (2..32)
- MIN_VAL, 0, lower window limit; MIN_VAL < MAX_VAL required
- MAX_VAL, 2**WIDTH-1, upper window limit; must fit in WIDTH bits
- SAT_MODE, 0, 0 = wrap at limits, 1 = saturate at limits

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset_n  input  1  synchronous, active-low reset
- en  input  1  count enable; counts one step per cycle when high
- up_dnb  input  1  direction: 1 = up, 0 = down
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value to load
- cnt  output  WIDTH  current count (registered)
- at_max  output  1  registered; high when cnt == MAX_VAL
- at_min  output  1  registered; high when cnt == MIN_VAL
- wrap  output  1  registered one-cycle pulse: the last update wrapped or hit saturation

## Operation
- Priority per rising edge: reset_n low > load > en > hold.
- Reset (reset_n sampled low): cnt = MIN_VAL, at_min = 1, at_max = 0, wrap = 0.
  - Reset mid-count discards any simultaneous load or enable.
- Load: cnt = load_val, clamped into [MIN_VAL, MAX_VAL]; wrap = 0. Load ignores en and up_dnb.
- Count (en = 1, load = 0): next value is cnt ± s, where s = 1, or the step input when configured.
  - Intermediate arithmetic uses WIDTH+1 bits so there is no silent overflow.
- Wrap mode, up: if cnt + s > MAX_VAL, next = MIN_VAL + (cnt + s − MAX_VAL − 1) and wrap = 1.
- Wrap mode, down: if cnt − s < MIN_VAL, next = MAX_VAL − (MIN_VAL − (cnt − s) − 1) and wrap = 1.
- Saturate mode: the result is clamped to MAX_VAL or MIN_VAL.
  - wrap = 1 only on the edge where clamping actually occurs.
  - Holding at a limit with en = 1 keeps cnt at the limit and re-asserts wrap every cycle.
- Hold (en = 0, load = 0): cnt unchanged; wrap = 0.
- at_max and at_min always reflect the registered cnt. They are never both high, because MIN_VAL < MAX_VAL.
- A direction change takes effect on the next enabled edge; no state is carried between directions.
- Initial count values outside the window are impossible: reset and load both land inside it.

## Timing
- All outputs are registered. cnt, at_max, at_min and wrap update together on the edge that samples the inputs. Latency is 1 cycle from input to output.
- There are no combinational paths from inputs to outputs.
- The wrap pulse is exactly one cycle per wrap/clamp event. Back-to-back wraps (e.g. step equal to the window size) give wrap high on consecutive cycles.
- Once reset_n is released, the first count occurs on the first edge that samples en = 1 with reset_n high.

## Configuration
- UP_DN_CNTR_STEP_EN defined: adds input port step [WIDTH-1:0] (after load_val).
  - s = step, clamped to the window size (MAX_VAL − MIN_VAL + 1).
  - step = 0 with en = 1 behaves as hold, with wrap = 0.
- UP_DN_CNTR_STEP_EN undefined: no step port; s is fixed at 1.
- Behaviour for s = 1 is identical in both builds.

## Test plan
All scenarios use WIDTH=4, MIN_VAL=2, MAX_VAL=12.

- **Reset:** reset_n = 0 for 3 cycles, then en = 1, up_dnb = 1.
  - Required: cnt = 2 and at_min = 1 during reset; cnt = 3 one cycle after release.
- **Wrap up (SAT_MODE=0):** count up from 2 for 11 enabled cycles.
  - Required: cnt reaches 12 with at_max = 1; next edge gives cnt = 2 with wrap = 1 for exactly one cycle.
- **Wrap down (SAT_MODE=0):** load 3, count down.
  - Required: sequence 3, 2, 12 with wrap = 1 on the 12; at_min = 1 on the 2.
- **Saturate (SAT_MODE=1):** load 11, count up 3 cycles.
  - Required: cnt = 12, 12, 12; wrap = 0, 1, 1.
  - Then count down from a loaded 2: cnt stays 2 and wrap = 1.
- **Priority/clamp:** load = 1 with load_val = 15 and en = 1 → cnt = 12.
  - Then reset_n = 0 together with load = 1 and load_val = 5 → cnt = 2.
  - Then en = 0 for 4 cycles → cnt holds at 2 with wrap = 0.
- **Step build (UP_DN_CNTR_STEP_EN):** step = 5, load 10, count up.
  - Required: 10 → 4 (wrap = 1) → 9 → 3 (wrap = 1).
  - Then step = 0: cnt holds at 3 with wrap = 0.
